// File: rtl/logic_bist_pkg.sv
// Shared types and constants for the 2-input gate self-test engine.
package logic_bist_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } bist_state_t;

  localparam int NUM_VEC = 4;

  // Bit index of each truth table is {A,B}.
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_XOR = 4'b0110;
endpackage

// File: rtl/logic_gate_bist.sv
// Self-test driver/checker for a 2-input gate: walks {A,B} through 00..11, samples Y at the end of each hold window.
// Run length 4*(SETTLE_CYCLES+1) cycles from the start edge; no flow control, start is ignored while busy.
module logic_gate_bist
  import logic_bist_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT_TT     = TT_AND,
  parameter int         ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a_o,
  output logic             b_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam logic [1:0]       LAST_VEC    = 2'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  bist_state_t      state_q, state_d;
  logic [1:0]       vec_idx_q, vec_idx_d;
  logic [7:0]       settle_q, settle_d;
  logic [1:0]       ab_q, ab_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             fail_valid_q, fail_valid_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic             mismatch;

  assign mismatch = (y_i != EXPECT_TT[vec_idx_q]);

  always_comb begin
    state_d      = state_q;
    vec_idx_d    = vec_idx_q;
    settle_d     = settle_q;
    ab_d         = ab_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_d      = HOLD;
          vec_idx_d    = 2'd0;
          settle_d     = 8'd0;
          ab_d         = 2'b00;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_count_d  = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 2'b00;
        end
      end
      HOLD: begin
        if (abort) begin
          // Error record is left intact so a cancelled run can still be inspected.
          state_d = IDLE;
          ab_d    = 2'b00;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (settle_q == SETTLE_LAST) begin
          if (mismatch) begin
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = vec_idx_q;
            end
          end
          settle_d = 8'd0;
          if (vec_idx_q == LAST_VEC) begin
            state_d = DONE;
            ab_d    = 2'b00;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
          end else begin
            vec_idx_d = vec_idx_q + 2'd1;
            ab_d      = vec_idx_q + 2'd1;
          end
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_idx_q    <= 2'd0;
      settle_q     <= 8'd0;
      ab_q         <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      settle_q     <= settle_d;
      ab_q         <= ab_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign a_o        = ab_q[1];
  assign b_o        = ab_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_logic_gate_bist.sv
// Directed bench for logic_gate_bist: default-parameter instance with a selectable gate model, plus a 1-bit/zero-settle instance.
module tb_logic_gate_bist;
  import logic_bist_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance under default parameters; the gate model is picked by gate_mode.
  logic       start = 1'b0, abort = 1'b0;
  logic       a_o, b_o, y_i, busy, done, pass, fail_valid;
  logic [2:0] err_count;
  logic [1:0] fail_vec;
  int         gate_mode = 0;  // 0 = AND, 1 = tied high, 2 = OR

  always_comb begin
    y_i = a_o & b_o;
    if (gate_mode == 1) y_i = 1'b1;
    else if (gate_mode == 2) y_i = a_o | b_o;
  end

  logic_gate_bist #(.SETTLE_CYCLES(2), .EXPECT_TT(TT_AND), .ERR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_o), .b_o(b_o), .y_i(y_i),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  // Narrow-counter, zero-settle instance with a stuck-high gate output.
  logic       start2 = 1'b0, abort2 = 1'b0, y2 = 1'b1;
  logic       a2, b2, busy2, done2, pass2, fail_valid2;
  logic [0:0] err2;
  logic [1:0] fail_vec2;

  logic_gate_bist #(.SETTLE_CYCLES(0), .EXPECT_TT(4'b1000), .ERR_W(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .a_o(a2), .b_o(b2), .y_i(y2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fail_valid2), .fail_vec(fail_vec2)
  );

  int applied = 0;
  int miscompares = 0;

  // All checks happen 1 time unit after a rising edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run;
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    applied++;
    if ({a_o, b_o, busy, done, pass, err_count, fail_valid, fail_vec} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_dut: got %b required 0", {a_o, b_o, busy, done, pass, err_count, fail_valid, fail_vec});
    end
    applied++;
    if ({a2, b2, busy2, done2, pass2, err2, fail_valid2, fail_vec2} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_dut2: got %b required 0", {a2, b2, busy2, done2, pass2, err2, fail_valid2, fail_vec2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(2);
  endtask

  task automatic test_and_run;
    logic [1:0] exp_ab;
    gate_mode = 0;
    start_run;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) wait_edges(1);
      exp_ab = (k == 12) ? 2'b00 : 2'(k / 3);
      applied++;
      if ({a_o, b_o} !== exp_ab || done !== (k == 12) || busy !== (k != 12)) begin
        miscompares++;
        $display("FAIL and_step%0d: ab=%b done=%b busy=%b required ab=%b done=%b busy=%b",
                 k, {a_o, b_o}, done, busy, exp_ab, (k == 12), (k != 12));
      end
    end
    applied++;
    if (pass !== 1'b1 || err_count !== 3'd0 || fail_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL and_result: pass=%b err=%0d fv=%b required 1 0 0", pass, err_count, fail_valid);
    end
  endtask

  task automatic test_done_start_abort;
    start = 1'b1;
    abort = 1'b1;
    wait_edges(1);
    start = 1'b0;
    abort = 1'b0;
    applied++;
    if (busy !== 1'b0 || done !== 1'b1 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL start_abort_in_done: busy=%b done=%b pass=%b required 0 1 1", busy, done, pass);
    end
  endtask

  task automatic test_stuck_high;
    gate_mode = 1;
    start_run;
    applied++;
    if (done !== 1'b0 || pass !== 1'b0 || err_count !== 3'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rerun_clear: done=%b pass=%b err=%0d busy=%b required 0 0 0 1", done, pass, err_count, busy);
    end
    wait_edges(12);
    applied++;
    if (done !== 1'b1 || err_count !== 3'd3 || fail_vec !== 2'b00 || fail_valid !== 1'b1 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_high: done=%b err=%0d fvec=%b fv=%b pass=%b required 1 3 00 1 0",
               done, err_count, fail_vec, fail_valid, pass);
    end
  endtask

  task automatic test_or_gate;
    gate_mode = 2;
    start_run;
    wait_edges(12);
    applied++;
    if (done !== 1'b1 || err_count !== 3'd2 || fail_vec !== 2'b01 || fail_valid !== 1'b1 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL or_gate: done=%b err=%0d fvec=%b fv=%b pass=%b required 1 2 01 1 0",
               done, err_count, fail_vec, fail_valid, pass);
    end
  endtask

  task automatic test_abort;
    gate_mode = 0;
    start_run;
    wait_edges(4);
    abort = 1'b1;
    wait_edges(1);
    abort = 1'b0;
    applied++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || {a_o, b_o} !== 2'b00 || err_count !== 3'd0) begin
      miscompares++;
      $display("FAIL abort: busy=%b done=%b pass=%b ab=%b err=%0d required 0 0 0 00 0",
               busy, done, pass, {a_o, b_o}, err_count);
    end
    start_run;
    wait_edges(12);
    applied++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL after_abort_run: done=%b pass=%b required 1 1", done, pass);
    end
  endtask

  task automatic test_async_reset;
    gate_mode = 1;
    start_run;
    wait_edges(4);
    #2 rst_n = 1'b0;
    #1;
    applied++;
    if ({a_o, b_o, busy, done, pass, err_count, fail_valid, fail_vec} !== 11'b0) begin
      miscompares++;
      $display("FAIL async_reset: got %b required 0", {a_o, b_o, busy, done, pass, err_count, fail_valid, fail_vec});
    end
    #2 rst_n = 1'b1;
    wait_edges(1);
    applied++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_start_while_busy;
    gate_mode = 0;
    start_run;
    wait_edges(5);
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
    wait_edges(5);
    applied++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_edge11: busy=%b done=%b required 1 0", busy, done);
    end
    wait_edges(1);
    applied++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_edge12: done=%b pass=%b busy=%b required 1 1 0", done, pass, busy);
    end
  endtask

  task automatic test_saturate_zero_settle;
    start2 = 1'b1;
    wait_edges(1);
    start2 = 1'b0;
    applied++;
    if (busy2 !== 1'b1 || err2 !== 1'b0 || {a2, b2} !== 2'b00) begin
      miscompares++;
      $display("FAIL sat_start: busy=%b err=%0d ab=%b required 1 0 00", busy2, err2, {a2, b2});
    end
    wait_edges(1);
    applied++;
    if (err2 !== 1'b1 || fail_valid2 !== 1'b1 || {a2, b2} !== 2'b01) begin
      miscompares++;
      $display("FAIL sat_edge1: err=%0d fv=%b ab=%b required 1 1 01", err2, fail_valid2, {a2, b2});
    end
    wait_edges(2);
    applied++;
    if (done2 !== 1'b0 || err2 !== 1'b1 || {a2, b2} !== 2'b11) begin
      miscompares++;
      $display("FAIL sat_edge3: done=%b err=%0d ab=%b required 0 1 11", done2, err2, {a2, b2});
    end
    wait_edges(1);
    applied++;
    if (done2 !== 1'b1 || pass2 !== 1'b0 || err2 !== 1'b1 || fail_vec2 !== 2'b00 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_done: done=%b pass=%b err=%0d fvec=%b busy=%b required 1 0 1 00 0",
               done2, pass2, err2, fail_vec2, busy2);
    end
  endtask

  initial begin
    test_reset;
    test_and_run;
    test_done_start_abort;
    test_stuck_high;
    test_or_gate;
    test_abort;
    test_async_reset;
    test_start_while_busy;
    test_saturate_zero_settle;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
